// File: rtl/edge_pkg.sv
// Shared edge-select encodings and arbiter state type for the edge event arbiter.
package edge_pkg;

    localparam logic [1:0] EDGE_NONE = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/edge_chan.sv
// One monitored channel: synchroniser, edge detect/qualify, pending event and sticky overflow.
module edge_chan
    import edge_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       data_i,
    input  logic       enable_i,
    input  logic [1:0] edge_sel_i,
    input  logic       detect_en_i,
    input  logic       grant_i,
    input  logic       ovf_clr_i,
    output logic       pend_o,
    output logic       pend_rise_o,
    output logic       overflow_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic dly_q;
    logic pend_q, pend_d;
    logic rise_q, rise_d;
    logic ovf_q, ovf_d;

    logic s, rise, fall, sel_rise, sel_fall, qual, lost;

    assign s        = sync_q[SYNC_STAGES-1];
    assign rise     = s & ~dly_q;
    assign fall     = ~s & dly_q;
    assign sel_rise = (edge_sel_i == EDGE_RISE) || (edge_sel_i == EDGE_BOTH);
    assign sel_fall = (edge_sel_i == EDGE_FALL) || (edge_sel_i == EDGE_BOTH);
    assign qual     = detect_en_i & enable_i & ((rise & sel_rise) | (fall & sel_fall));

    // A grant frees the slot in the same cycle, so a coincident edge is stored rather than lost.
    always_comb begin
        pend_d = pend_q;
        rise_d = rise_q;
        ovf_d  = ovf_q;
        lost   = 1'b0;
        if (!enable_i) begin
            pend_d = 1'b0;
        end else if (qual) begin
            if (pend_q && !grant_i) begin
                lost = 1'b1;
            end else begin
                pend_d = 1'b1;
                rise_d = rise;
            end
        end else if (grant_i) begin
            pend_d = 1'b0;
        end
        if (lost) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            pend_q <= 1'b0;
            rise_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], data_i};
            dly_q  <= s;
            pend_q <= pend_d;
            rise_q <= rise_d;
            ovf_q  <= ovf_d;
        end
    end

    assign pend_o      = pend_q;
    assign pend_rise_o = rise_q;
    assign overflow_o  = ovf_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge event arbiter top: warm-up mask, round-robin selection of pending channel events
// and the registered valid/ready event port.
module edge_event_arbiter
    import edge_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned ID_W        = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NUM_CH-1:0]   data_in,
    input  logic [NUM_CH-1:0]   ch_enable,
    input  logic [2*NUM_CH-1:0] edge_sel,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [ID_W-1:0]     evt_ch,
    output logic                evt_edge,
    output logic [NUM_CH-1:0]   overflow,
    input  logic                overflow_clr
);

    localparam int unsigned WARM_MAX = SYNC_STAGES + 1;
    localparam int unsigned WARM_W   = $clog2(WARM_MAX + 1);

    logic [WARM_W-1:0] warm_q, warm_d;
    logic              detect_en;

    arb_state_e        state_q, state_d;
    logic              valid_q, valid_d;
    logic [ID_W-1:0]   ch_q, ch_d;
    logic              edge_q, edge_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;

    logic [NUM_CH-1:0] pend, pend_rise, req, grant_vec;
    logic [ID_W-1:0]   base, win;
    logic              take;

    // Detection stays masked until the synchroniser and delay stage hold post-reset data.
    assign detect_en = (warm_q == WARM_W'(WARM_MAX));
    assign warm_d    = detect_en ? warm_q : warm_q + WARM_W'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_chan (
            .clock      (clock),
            .reset_n    (reset_n),
            .data_i     (data_in[i]),
            .enable_i   (ch_enable[i]),
            .edge_sel_i (edge_sel[2*i +: 2]),
            .detect_en_i(detect_en),
            .grant_i    (grant_vec[i]),
            .ovf_clr_i  (overflow_clr),
            .pend_o     (pend[i]),
            .pend_rise_o(pend_rise[i]),
            .overflow_o (overflow[i])
        );
    end

    assign req = pend & ch_enable;

    // First requesting channel after base, wrapping; base itself is considered last.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_CH-1:0] r,
                                                input logic [ID_W-1:0]   b);
        logic [ID_W-1:0] w;
        logic [ID_W-1:0] idx;
        w = '0;
        for (int unsigned k = NUM_CH; k >= 1; k--) begin
            idx = ID_W'((32'(b) + k) % NUM_CH);
            if (r[idx]) begin
                w = idx;
            end
        end
        return w;
    endfunction

    assign win = rr_pick(req, base);

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        ch_d      = ch_q;
        edge_d    = edge_q;
        ptr_d     = ptr_q;
        grant_vec = '0;
        base      = ptr_q;
        take      = 1'b0;
        case (state_q)
            IDLE: take = 1'b1;
            HOLD: begin
                if (evt_ready) begin
                    ptr_d   = ch_q;
                    base    = ch_q;
                    take    = 1'b1;
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
        if (take && (|req)) begin
            grant_vec[win] = 1'b1;
            ch_d           = win;
            edge_d         = pend_rise[win];
            state_d        = HOLD;
            valid_d        = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            warm_q  <= '0;
            state_q <= IDLE;
            valid_q <= 1'b0;
            ch_q    <= '0;
            edge_q  <= 1'b0;
            ptr_q   <= ID_W'(NUM_CH - 1);
        end else begin
            warm_q  <= warm_d;
            state_q <= state_d;
            valid_q <= valid_d;
            ch_q    <= ch_d;
            edge_q  <= edge_d;
            ptr_q   <= ptr_d;
        end
    end

    assign evt_valid = valid_q;
    assign evt_ch    = ch_q;
    assign evt_edge  = edge_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: single-edge vector table plus multi-cycle sequences.
module tb_edge_event_arbiter;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] data_in;
    logic [3:0] ch_enable;
    logic [7:0] edge_sel;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_ch;
    logic       evt_edge;
    logic [3:0] overflow;
    logic       overflow_clr;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt;

    typedef struct {
        int         ch;
        logic [1:0] sel;
        logic       en;
        logic       lvl0;
        logic       lvl1;
        logic       exp_evt;
        logic       exp_edge;
    } vec_t;

    vec_t vecs[8];

    edge_event_arbiter #(.NUM_CH(4), .ID_W(2), .SYNC_STAGES(2)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .data_in     (data_in),
        .ch_enable   (ch_enable),
        .edge_sel    (edge_sel),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_ch      (evt_ch),
        .evt_edge    (evt_edge),
        .overflow    (overflow),
        .overflow_clr(overflow_clr)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n      = 1'b0;
        data_in      = '0;
        ch_enable    = 4'hF;
        edge_sel     = '0;
        evt_ready    = 1'b0;
        overflow_clr = 1'b0;

        //            ch  sel    en    lvl0  lvl1  evt   edge
        vecs[0] = '{1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{3, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{2, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{2, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        for (int v = 0; v < 8; v++) begin
            evt_ready                 = 1'b1;
            ch_enable                 = 4'hF;
            ch_enable[vecs[v].ch]     = vecs[v].en;
            edge_sel                  = '0;
            edge_sel[2*vecs[v].ch +: 2] = vecs[v].sel;
            data_in                   = '0;
            data_in[vecs[v].ch]       = vecs[v].lvl0;
            do_reset();
            check($sformatf("v%0d reset valid", v), 32'(evt_valid), 32'd0);
            check($sformatf("v%0d reset ovf", v), 32'(overflow), 32'd0);
            step(6);
            check($sformatf("v%0d warmup valid", v), 32'(evt_valid), 32'd0);
            data_in[vecs[v].ch] = vecs[v].lvl1;
            step(3);
            check($sformatf("v%0d early valid", v), 32'(evt_valid), 32'd0);
            step(1);
            check($sformatf("v%0d lat4 valid", v), 32'(evt_valid), 32'(vecs[v].exp_evt));
            if (vecs[v].exp_evt) begin
                check($sformatf("v%0d ch", v), 32'(evt_ch), 32'(vecs[v].ch));
                check($sformatf("v%0d edge", v), 32'(evt_edge), 32'(vecs[v].exp_edge));
            end
            step(1);
            check($sformatf("v%0d one-cycle valid", v), 32'(evt_valid), 32'd0);
        end

        // Simultaneous rises on ch0/ch2, then simultaneous falls: round-robin order.
        evt_ready = 1'b1; ch_enable = 4'hF; edge_sel = 8'hFF; data_in = '0;
        do_reset();
        step(6);
        data_in = 4'b0101;
        step(4);
        check("rr rise first", {evt_valid, evt_ch, evt_edge}, {1'b1, 2'd0, 1'b1});
        step(1);
        check("rr rise second", {evt_valid, evt_ch, evt_edge}, {1'b1, 2'd2, 1'b1});
        step(1);
        check("rr rise idle", 32'(evt_valid), 32'd0);
        data_in = 4'b0000;
        step(4);
        check("rr fall first", {evt_valid, evt_ch, evt_edge}, {1'b1, 2'd0, 1'b0});
        step(1);
        check("rr fall second", {evt_valid, evt_ch, evt_edge}, {1'b1, 2'd2, 1'b0});
        step(1);
        check("rr fall idle", 32'(evt_valid), 32'd0);

        // Backpressure: rise held stable, fall waits pending without overflow.
        evt_ready = 1'b0; edge_sel = 8'hC0; data_in = '0;
        do_reset();
        step(6);
        data_in[3] = 1'b1;
        step(3);
        data_in[3] = 1'b0;
        step(2);
        check("bp hold early", {evt_valid, evt_ch, evt_edge}, {1'b1, 2'd3, 1'b1});
        step(5);
        check("bp hold late", {evt_valid, evt_ch, evt_edge}, {1'b1, 2'd3, 1'b1});
        check("bp no ovf", 32'(overflow), 32'd0);
        evt_ready = 1'b1;
        step(1);
        check("bp fall next", {evt_valid, evt_ch, evt_edge}, {1'b1, 2'd3, 1'b0});
        step(1);
        check("bp drained", 32'(evt_valid), 32'd0);

        // Two full pulses under backpressure: overflow, exactly two events delivered.
        evt_ready = 1'b0; data_in = '0;
        do_reset();
        step(6);
        for (int p = 0; p < 2; p++) begin
            data_in[3] = 1'b1; step(3);
            data_in[3] = 1'b0; step(3);
        end
        step(4);
        check("ovf set", 32'(overflow), 32'h8);
        check("ovf first evt", {evt_valid, evt_ch, evt_edge}, {1'b1, 2'd3, 1'b1});
        evt_ready = 1'b1;
        step(1);
        check("ovf second evt", {evt_valid, evt_ch, evt_edge}, {1'b1, 2'd3, 1'b0});
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (evt_valid) cnt++;
        end
        check("ovf no extra evt", 32'(cnt), 32'd0);
        check("ovf sticky", 32'(overflow), 32'h8);
        overflow_clr = 1'b1;
        step(1);
        overflow_clr = 1'b0;
        check("ovf cleared", 32'(overflow), 32'd0);

        // ch2 high through reset produces nothing; then a pending ch2 event is flushed by disable.
        evt_ready = 1'b1; edge_sel = 8'h31; ch_enable = 4'hF; data_in = 4'b0100;
        do_reset();
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (evt_valid) cnt++;
        end
        check("held-high no evt", 32'(cnt), 32'd0);
        evt_ready = 1'b0;
        data_in = 4'b0001;
        step(4);
        check("flush ch0 shown", {evt_valid, evt_ch, evt_edge}, {1'b1, 2'd0, 1'b1});
        ch_enable[2] = 1'b0;
        step(1);
        ch_enable[2] = 1'b1;
        step(1);
        evt_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (evt_valid) cnt++;
        end
        check("flushed ch2 absent", 32'(cnt), 32'd0);

        // Asynchronous reset while an event is presented.
        evt_ready = 1'b0; edge_sel = 8'hC0; data_in = '0;
        do_reset();
        step(6);
        data_in[3] = 1'b1;
        step(4);
        check("pre-reset valid", {evt_valid, evt_ch, evt_edge}, {1'b1, 2'd3, 1'b1});
        #2;
        reset_n = 1'b0;
        #1;
        check("async rst outputs", {evt_valid, evt_ch, evt_edge, overflow}, 8'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
